// File: rtl/image_load_sequencer.sv
// rtl/image_load_sequencer.sv - serialises compressed image rows into words, then forwards CNN data.
// One shift register carries the row being streamed and, in CNN phase, the single buffered CNN word.
module image_load_sequencer #(
  parameter int ROW_W    = 480,
  parameter int WORD_W   = 16,
  parameter int NUM_ROWS = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROW_W-1:0]  row_in,
  input  logic              send,
  input  logic              stop,
  output logic              row_ready,
  input  logic [WORD_W-1:0] cnn_data_in,
  input  logic              cnn_valid,
  input  logic              cnn_last,
  output logic              cnn_ready,
  output logic [WORD_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              start_decompression,
  output logic [15:0]       row_size,
  output logic              cnn_image,
  output logic              load_process
);

  localparam int WORDS = ROW_W / WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = $clog2(NUM_ROWS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] ROWS_END = CNT_W'(NUM_ROWS);

  typedef enum logic [1:0] {IDLE, STREAM, CNN, DONE} state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   rows_q, rows_d;
  logic               hold_q, hold_d;
  logic               last_q, last_d;
  logic               start_q, start_d;
  logic               cnn_image_q, cnn_image_d;
  logic               load_q, load_d;
  logic               xfer;

  assign row_size            = 16'(WORDS);
  assign data                = shift_q[WORD_W-1:0];
  assign row_ready           = (state_q == IDLE) && !stop && !rst;
  assign data_valid          = !stop && ((state_q == STREAM) || ((state_q == CNN) && hold_q));
  assign cnn_ready           = (state_q == CNN) && !stop && (!hold_q || data_ready);
  assign start_decompression = start_q;
  assign cnn_image           = cnn_image_q;
  assign load_process        = load_q;
  assign xfer                = data_valid && data_ready;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    rows_d      = rows_q;
    hold_d      = hold_q;
    last_d      = last_q;
    start_d     = 1'b0;
    cnn_image_d = cnn_image_q;
    load_d      = load_q;
    case (state_q)
      IDLE: begin
        if (send && !stop) begin
          shift_d = row_in;
          idx_d   = '0;
          start_d = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          shift_d = shift_q >> WORD_W;
          if (idx_q == LAST_IDX) begin
            rows_d = rows_q + 1'b1;
            if (rows_d == ROWS_END) begin
              state_d     = CNN;
              cnn_image_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      CNN: begin
        // Delivering the last word ends the load; a word offered on that same edge is dropped.
        if (xfer && last_q) begin
          state_d = DONE;
          load_d  = 1'b0;
          hold_d  = 1'b0;
        end else if (cnn_valid && cnn_ready) begin
          shift_d = ROW_W'(cnn_data_in);
          hold_d  = 1'b1;
          last_d  = cnn_last;
        end else if (xfer) begin
          hold_d = 1'b0;
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      rows_q      <= '0;
      hold_q      <= 1'b0;
      last_q      <= 1'b0;
      start_q     <= 1'b0;
      cnn_image_q <= 1'b0;
      load_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      rows_q      <= rows_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      start_q     <= start_d;
      cnn_image_q <= cnn_image_d;
      load_q      <= load_d;
    end
  end

endmodule
